// File: rtl/st7789_ctrl.sv
// ST7789 panel controller: power-on reset sequencing plus a write-only serial shifter that
// sends command/parameter bytes and RGB565 pixels (two bytes, MSB first) with SCL idling high.
module st7789_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned RST_CYCLES  = 1000,
    parameter int unsigned WAIT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    input  logic        cmd_dc_i,
    input  logic [7:0]  cmd_data_i,
    output logic        cmd_ready_o,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    output logic        pix_ready_o,
    output logic        busy_o,
    output logic        st7789_SCL,
    output logic        st7789_SDA,
    output logic        st7789_DC,
    output logic        st7789_RES
);

    localparam int unsigned RstMax = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int unsigned RW     = $clog2(RstMax + 1);
    localparam int unsigned HW     = $clog2(CLK_DIV + 1);

    localparam logic [RW-1:0] RstLast  = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] WaitLast = RW'(WAIT_CYCLES - 1);
    localparam logic [HW-1:0] HalfLast = HW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StRstHold, StRstWait, StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;   // bits still to send after the current one
    logic [15:0]   shreg_q, shreg_d;
    logic          scl_q, scl_d;
    logic          dc_q, dc_d;
    logic          start;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRstHold;
            rst_cnt_q  <= '0;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            scl_q      <= 1'b1;
            dc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            scl_q      <= scl_d;
            dc_q       <= dc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        half_cnt_d  = half_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        scl_d       = scl_q;
        dc_d        = dc_q;
        start       = 1'b0;
        cmd_ready_o = 1'b0;
        pix_ready_o = 1'b0;

        unique case (state_q)
            StRstHold: begin
                if (rst_cnt_q == RstLast) begin
                    state_d   = StRstWait;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StRstWait: begin
                if (rst_cnt_q == WaitLast) begin
                    state_d   = StIdle;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                cmd_ready_o = 1'b1;
                pix_ready_o = !cmd_valid_i;
                // Commands win over pixels; the pixel simply stays pending.
                if (cmd_valid_i) begin
                    shreg_d   = {cmd_data_i, 8'h00};
                    dc_d      = cmd_dc_i;
                    bit_cnt_d = 4'd7;
                    start     = 1'b1;
                end else if (pix_valid_i) begin
                    shreg_d   = pix_data_i;
                    dc_d      = 1'b1;
                    bit_cnt_d = 4'd15;
                    start     = 1'b1;
                end
                if (start) begin
                    state_d    = StShift;
                    scl_d      = 1'b0;
                    half_cnt_d = '0;
                end
            end
            StShift: begin
                if (half_cnt_q == HalfLast) begin
                    half_cnt_d = '0;
                    if (!scl_q) begin
                        scl_d = 1'b1;
                    end else if (bit_cnt_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        // Next bit appears on SDA together with the falling SCL edge.
                        scl_d     = 1'b0;
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            default: state_d = StRstHold;
        endcase
    end

    assign busy_o     = (state_q != StIdle);
    assign st7789_SCL = scl_q;
    assign st7789_SDA = shreg_q[15];
    assign st7789_DC  = dc_q;
    assign st7789_RES = (state_q != StRstHold);

endmodule
